// File: rtl/fpmult_round_stage.sv
// Round-to-nearest-even and IEEE packing stage of the FP multiplier.
// Two-deep valid/ready pipeline: stage 1 holds the rounded exponent and
// mantissa plus class bits, stage 2 holds the packed result and flags.
//
// Handshake: a beat moves across a boundary on the rising edge where its
// valid and the downstream ready are both high. The valid and payload of a
// beat stay unchanged until it is taken. in_ready depends combinationally on
// out_ready and on nothing else from the input side.
module fpmult_round_stage #(
  parameter int EXPONENT = 5,
  parameter int MANTISSA = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sign,
  input  logic [EXPONENT-1:0]          in_round_e,
  input  logic [EXPONENT-1:0]          in_round_ep,
  input  logic [MANTISSA-1:0]          in_round_m,
  input  logic [MANTISSA-1:0]          in_round_mp,
  input  logic [2:0]                   in_grs,
  input  logic                         in_nan,
  input  logic                         in_inf,
  input  logic                         in_zero,
  input  logic                         in_ovf,
  input  logic                         in_unf,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXPONENT+MANTISSA:0]   out_z,
  output logic [4:0]                   out_flags
);

  localparam int W = EXPONENT + MANTISSA + 1;

  // Canonical quiet NaN: exponent all ones, top mantissa bit set.
  localparam logic [W-1:0] NAN_Z = {1'b0, {EXPONENT{1'b1}}, 1'b1, {(MANTISSA-1){1'b0}}};

  // Flag vector layout {invalid, overflow, underflow, inexact, zero}.
  localparam logic [4:0] FLG_INVALID = 5'b10000;
  localparam logic [4:0] FLG_OVF     = 5'b01010;
  localparam logic [4:0] FLG_UNF     = 5'b00111;
  localparam logic [4:0] FLG_ZERO    = 5'b00001;

  // Stage 1 state.
  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q;
  logic [EXPONENT-1:0] s1_exp_q;
  logic [MANTISSA-1:0] s1_mant_q;
  logic                s1_inexact_q;
  logic                s1_nan_q, s1_inf_q, s1_zero_q, s1_unf_q, s1_eovf_q;

  // Stage 2 state (drives the outputs directly).
  logic                s2_valid_q, s2_valid_d;
  logic [W-1:0]        z_q, z_d;
  logic [4:0]          flags_q, flags_d;

  // Rounding decision and candidate selection.
  logic                round_up;
  logic                carry;
  logic [EXPONENT-1:0] sel_exp;
  logic [MANTISSA-1:0] sel_mant;

  logic                advance;
  logic                accept;

  // Round-to-nearest-even: pick the incremented candidates when rounding up,
  // and the incremented exponent only when the mantissa wraps.
  always_comb begin
    round_up = in_grs[2] & (in_grs[1] | in_grs[0] | in_round_m[0]);
    carry    = round_up & (&in_round_m);
    sel_mant = round_up ? in_round_mp : in_round_m;
    sel_exp  = carry ? in_round_ep : in_round_e;
  end

  // Pipeline control: stage 2 drains or is empty, stage 1 follows it.
  always_comb begin
    advance    = !s2_valid_q | out_ready;
    in_ready   = !s1_valid_q | advance;
    accept     = in_valid & in_ready;
    s1_valid_d = accept ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
    s2_valid_d = advance ? s1_valid_q : s2_valid_q;
  end

  // Exception and range handling in priority order.
  always_comb begin
    z_d     = {s1_sign_q, s1_exp_q, s1_mant_q};
    flags_d = {3'b000, s1_inexact_q, 1'b0};
    if (s1_nan_q) begin
      z_d     = NAN_Z;
      flags_d = FLG_INVALID;
    end else if (s1_inf_q) begin
      z_d     = {s1_sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      flags_d = 5'b00000;
    end else if (s1_zero_q) begin
      z_d     = {s1_sign_q, {(W-1){1'b0}}};
      flags_d = FLG_ZERO;
    end else if (s1_eovf_q) begin
      z_d     = {s1_sign_q, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
      flags_d = FLG_OVF;
    end else if (s1_unf_q) begin
      // No subnormals: underflow always flushes to a signed zero.
      z_d     = {s1_sign_q, {(W-1){1'b0}}};
      flags_d = FLG_UNF;
    end
  end

  // Stage 1 register: captures the rounded fields on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_mant_q    <= '0;
      s1_inexact_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_inf_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_unf_q     <= 1'b0;
      s1_eovf_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_sign_q    <= in_sign;
        s1_exp_q     <= sel_exp;
        s1_mant_q    <= sel_mant;
        s1_inexact_q <= |in_grs;
        s1_nan_q     <= in_nan;
        s1_inf_q     <= in_inf;
        s1_zero_q    <= in_zero;
        s1_unf_q     <= in_unf;
        s1_eovf_q    <= in_ovf | (&sel_exp);
      end
    end
  end

  // Stage 2 register: packed result, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      z_q        <= '0;
      flags_q    <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (advance && s1_valid_q) begin
        z_q     <= z_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_z     = z_q;
  assign out_flags = flags_q;

endmodule

// File: tb/tb_fpmult_round_stage.sv
// Bench for fpmult_round_stage: directed rounding/exception cases, random
// traffic with random backpressure, a scripted stall, and mid-stream reset.
module tb_fpmult_round_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_round_e, in_round_ep;
  logic [9:0]  in_round_m, in_round_mp;
  logic [2:0]  in_grs;
  logic        in_nan, in_inf, in_zero, in_ovf, in_unf;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_z;
  logic [4:0]  out_flags;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: {flags, z} expected per accepted beat, plus accept cycle.
  logic [20:0] exp_q[$];
  int          cyc_q[$];
  int          cyc = 0;

  // Directed beats may carry a literal expected value instead of the model's.
  logic        ovr_en = 1'b0;
  logic [20:0] ovr_val = '0;

  logic        stall_prev = 1'b0;
  logic [15:0] prev_z;
  logic [4:0]  prev_flags;

  fpmult_round_stage #(.EXPONENT(5), .MANTISSA(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign),
    .in_round_e(in_round_e), .in_round_ep(in_round_ep),
    .in_round_m(in_round_m), .in_round_mp(in_round_mp),
    .in_grs(in_grs),
    .in_nan(in_nan), .in_inf(in_inf), .in_zero(in_zero),
    .in_ovf(in_ovf), .in_unf(in_unf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: rounding as integer arithmetic, then class priority.
  function automatic logic [20:0] ref_model(input logic s, input int e, input int m,
                                           input logic [2:0] grs, input logic nan,
                                           input logic inf, input logic zero,
                                           input logic ovf, input logic unf);
    int ru;
    int sum;
    int ex;
    int mant;
    logic inx;
    ru   = (grs[2] && (grs[1] || grs[0] || (m % 2 == 1))) ? 1 : 0;
    sum  = m + ru;
    ex   = e;
    mant = sum;
    if (sum == 1024) begin
      ex   = e + 1;
      mant = 0;
    end
    inx = (grs != 3'b000);
    if (nan)                  return {5'b10000, 16'h7E00};
    if (inf)                  return {5'b00000, s, 5'h1F, 10'h000};
    if (zero)                 return {5'b00001, s, 15'h0000};
    if (ovf || ex == 31)      return {5'b01010, s, 5'h1F, 10'h000};
    if (unf)                  return {5'b00111, s, 15'h0000};
    return {3'b000, inx, 1'b0, s, ex[4:0], mant[9:0]};
  endfunction

  // Monitor/scoreboard, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      cyc_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_z", {16'd0, out_z}, {16'd0, prev_z});
        check("hold_flags", {27'd0, out_flags}, {27'd0, prev_flags});
      end
      check("in_ready", {31'd0, in_ready},
            {31'd0, (exp_q.size() < 2) || out_ready});
      check("out_valid", {31'd0, out_valid},
            {31'd0, (exp_q.size() > 0) && (cyc - cyc_q[0] >= 2)});
      if (out_valid && out_ready && exp_q.size() > 0) begin
        check("out_z", {16'd0, out_z}, {16'd0, exp_q[0][15:0]});
        check("out_flags", {27'd0, out_flags}, {27'd0, exp_q[0][20:16]});
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (ovr_en) exp_q.push_back(ovr_val);
        else exp_q.push_back(ref_model(in_sign, int'(in_round_e), int'(in_round_m), in_grs,
                                       in_nan, in_inf, in_zero, in_ovf, in_unf));
        cyc_q.push_back(cyc);
      end
      stall_prev = out_valid && !out_ready;
      prev_z     = out_z;
      prev_flags = out_flags;
    end
    cyc++;
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic set_f(input logic s, input logic [4:0] e, input logic [4:0] ep,
                       input logic [9:0] m, input logic [9:0] mp, input logic [2:0] grs,
                       input logic nan, input logic inf, input logic zero,
                       input logic ovf, input logic unf);
    in_sign = s; in_round_e = e; in_round_ep = ep; in_round_m = m; in_round_mp = mp;
    in_grs = grs; in_nan = nan; in_inf = inf; in_zero = zero; in_ovf = ovf; in_unf = unf;
  endtask

  task automatic rand_fields();
    logic [4:0] e;
    logic [9:0] m;
    e = 5'($urandom_range(1, 30));
    m = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom_range(0, 1023));
    set_f(1'($urandom), e, e + 5'd1, m, m + 10'd1, 3'($urandom),
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 7) == 0);
  endtask

  task automatic idle(input int n, input logic ordy);
    in_valid  = 1'b0;
    out_ready = ordy;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [20:0] expv, input logic use_exp, input logic ordy);
    logic acc;
    acc       = 1'b0;
    ovr_en    = use_exp;
    ovr_val   = expv;
    in_valid  = 1'b1;
    out_ready = ordy;
    for (int k = 0; k < 20; k++) begin
      #1 acc = in_ready;
      @(posedge clk);
      #2;
      if (acc) break;
    end
    if (!acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    ovr_en   = 1'b0;
  endtask

  initial begin
    logic acc;
    int   sent;
    logic saw_stall;

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_f(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_z", {16'd0, out_z}, 32'd0);
    check("rst_out_flags", {27'd0, out_flags}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed rounding and exception cases with literal expectations.
    set_f(0, 5'h10, 5'h11, 10'h080, 10'h081, 3'b000, 0, 0, 0, 0, 0);
    send_beat({5'b00000, 16'h4080}, 1, 1);
    set_f(0, 5'h10, 5'h11, 10'h001, 10'h002, 3'b100, 0, 0, 0, 0, 0);
    send_beat({5'b00010, 16'h4002}, 1, 1);
    set_f(0, 5'h10, 5'h11, 10'h002, 10'h003, 3'b100, 0, 0, 0, 0, 0);
    send_beat({5'b00010, 16'h4002}, 1, 1);
    set_f(0, 5'h10, 5'h11, 10'h002, 10'h003, 3'b101, 0, 0, 0, 0, 0);
    send_beat({5'b00010, 16'h4003}, 1, 1);
    set_f(0, 5'h10, 5'h11, 10'h3FF, 10'h000, 3'b110, 0, 0, 0, 0, 0);
    send_beat({5'b00010, 16'h4400}, 1, 1);
    set_f(0, 5'h1E, 5'h1F, 10'h3FF, 10'h000, 3'b110, 0, 0, 0, 0, 0);
    send_beat({5'b01010, 16'h7C00}, 1, 1);
    set_f(0, 5'h10, 5'h11, 10'h000, 10'h001, 3'b000, 1, 1, 0, 0, 0);
    send_beat({5'b10000, 16'h7E00}, 1, 1);
    set_f(1, 5'h10, 5'h11, 10'h000, 10'h001, 3'b000, 0, 0, 0, 0, 1);
    send_beat({5'b00111, 16'h8000}, 1, 1);
    idle(4, 1);

    // Random traffic with random consumer backpressure.
    acc = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (!in_valid || acc) begin
        rand_fields();
        in_valid = ($urandom_range(0, 9) < 7);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1 acc = in_valid & in_ready;
      @(posedge clk);
      #2;
    end
    idle(6, 1);
    check("rand_drain", exp_q.size(), 32'd0);

    // Scripted stall: consumer blocks for cycles 2..6 of a 5-beat stream.
    sent = 0;
    saw_stall = 1'b0;
    acc = 1'b1;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      if (acc) rand_fields();
      in_valid  = 1'b1;
      out_ready = !(c >= 2 && c <= 6);
      #1 acc = in_ready;
      if (!in_ready) saw_stall = 1'b1;
      if (in_ready) sent++;
      @(posedge clk);
      #2;
    end
    in_valid = 1'b0;
    check("bp_sent", sent, 32'd5);
    check("bp_in_ready_drop", {31'd0, saw_stall}, 32'd1);
    idle(8, 1);
    check("bp_drain", exp_q.size(), 32'd0);

    // Reset with two beats in flight.
    set_f(0, 5'h12, 5'h13, 10'h155, 10'h156, 3'b000, 0, 0, 0, 0, 0);
    send_beat(21'd0, 0, 0);
    set_f(1, 5'h08, 5'h09, 10'h2AA, 10'h2AB, 3'b011, 0, 0, 0, 0, 0);
    send_beat(21'd0, 0, 0);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_z", {16'd0, out_z}, 32'd0);
    check("mid_rst_out_flags", {27'd0, out_flags}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    idle(1, 1);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    set_f(0, 5'h10, 5'h11, 10'h080, 10'h081, 3'b000, 0, 0, 0, 0, 0);
    send_beat({5'b00000, 16'h4080}, 1, 1);
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #2;
    check("post_rst_lat2", {31'd0, out_valid}, 32'd1);
    check("post_rst_z", {16'd0, out_z}, 32'h4080);
    idle(4, 1);
    check("final_drain", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
